// File: rtl/gups_engine_if.sv
// Memory port of the GUPS engine: one outstanding read or write, completed by a single ready strobe.
interface gups_engine_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              req;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] dout;
  logic [DATA_W-1:0] data_in;
  logic              ready;

  modport master (
    output req, write, address, dout,
    input  data_in, ready
  );

  modport slave (
    input  req, write, address, dout,
    output data_in, ready
  );
endinterface

// File: rtl/gups_engine.sv
// LFSR-addressed read-modify-write update engine; 3 cycles per update with ready held high.
// Waits indefinitely for ready in RD/WR with req and address held; abort ends the run after the current update.
module gups_engine #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32,
  parameter     POLY   = 64'h7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [DATA_W-1:0]   seed,
  input  logic [ADDR_W-1:0]   range,
  input  logic [CNT_W-1:0]    num_updates,
  input  logic                mode,
  gups_engine_if.master       mem,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    update_count
);

  localparam logic [DATA_W-1:0] POLY_T = DATA_W'(POLY);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GEN  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] ran;
  logic [DATA_W-1:0] ran_next;
  logic [DATA_W-1:0] upd;
  logic [ADDR_W-1:0] range_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_inc;
  logic              mode_q;
  logic              abort_pend;
  logic              last_update;

  assign ran_next    = {ran[DATA_W-2:0], 1'b0} ^ (ran[DATA_W-1] ? POLY_T : '0);
  assign count_inc   = count + 1'b1;
  // An abort seen in the same WR cycle as ready still finishes the run here.
  assign last_update = (count_inc == num_q) || abort_pend || abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ran        <= '0;
      upd        <= '0;
      range_q    <= '0;
      num_q      <= '0;
      count      <= '0;
      mode_q     <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          abort_pend <= 1'b0;
          if (start) begin
            num_q   <= num_updates;
            range_q <= range;
            mode_q  <= mode;
            ran     <= (seed == '0) ? DATA_W'(1) : seed;
            count   <= '0;
            state   <= (num_updates == '0) ? S_DONE : S_GEN;
          end
        end
        S_GEN: begin
          if (abort) begin
            abort_pend <= 1'b1;
            state      <= S_DONE;
          end else begin
            ran   <= ran_next;
            state <= S_RD;
          end
        end
        S_RD: begin
          if (abort) abort_pend <= 1'b1;
          if (mem.ready) begin
            upd   <= mode_q ? (mem.data_in + 1'b1) : (mem.data_in ^ ran);
            state <= S_WR;
          end
        end
        S_WR: begin
          if (abort) abort_pend <= 1'b1;
          if (mem.ready) begin
            count <= count_inc;
            state <= last_update ? S_DONE : S_GEN;
          end
        end
        S_DONE: begin
          if (abort) abort_pend <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem.req      = (state == S_RD) || (state == S_WR);
  assign mem.write    = (state == S_WR);
  assign mem.address  = ran[ADDR_W-1:0] & range_q;
  assign mem.dout     = upd;
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign update_count = count;

  a_req_held: assert property (@(posedge clk) disable iff (reset)
    (mem.req && !mem.ready) |=> (mem.req && $stable(mem.address) && $stable(mem.write)));

  a_write_in_req: assert property (@(posedge clk) disable iff (reset)
    mem.write |-> mem.req);

endmodule

// File: tb/tb_gups_engine.sv
// Directed bench for gups_engine: table of full runs with ready held high plus hand-written corner sequences.
module tb_gups_engine;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          abort;
  logic [DW-1:0] seed;
  logic [AW-1:0] range;
  logic [CW-1:0] num_updates;
  logic          mode;
  logic          busy;
  logic          done;
  logic [CW-1:0] update_count;

  gups_engine_if #(.DATA_W(DW), .ADDR_W(AW)) mem ();

  gups_engine #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .POLY(64'h7)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .seed         (seed),
    .range        (range),
    .num_updates  (num_updates),
    .mode         (mode),
    .mem          (mem),
    .busy         (busy),
    .done         (done),
    .update_count (update_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] seed;
    logic [63:0] rng;
    logic [31:0] num;
    logic        mode;
    logic [63:0] din;
    logic [63:0] a_first;
    logic [63:0] d_first;
    logic [63:0] a_last;
    logic [63:0] d_last;
  } vec_t;

  vec_t vecs[6];

  // Full run with ready=1 and constant data_in. With disturb set, inputs change after the
  // start edge and start is re-pulsed mid-run; the results must be unaffected.
  task automatic run_vec(input int idx, input vec_t v, input bit disturb);
    int          done_k = -1;
    int          first_req_k = -1;
    int          nwr = 0;
    int          nreq = 0;
    logic [63:0] af = '0, df = '0, al = '0, dl = '0;
    seed        = v.seed;
    range       = v.rng;
    num_updates = v.num;
    mode        = v.mode;
    mem.data_in = v.din;
    mem.ready   = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (disturb) begin
      num_updates = 32'd1;
      range       = '0;
      mode        = ~v.mode;
    end
    for (int k = 0; k < 3 * int'(v.num) + 10 && done_k < 0; k++) begin
      if (mem.req && first_req_k < 0) first_req_k = k;
      if (mem.req && mem.write) begin
        if (nwr == 0) begin
          af = mem.address;
          df = mem.dout;
        end
        al = mem.address;
        dl = mem.dout;
        nwr++;
      end
      if (done) begin
        done_k = k;
      end else begin
        start = disturb && (k == 1 || k == 4);
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk($sformatf("v%0d_done_cycle", idx), done_k, 3 * int'(v.num));
    chk($sformatf("v%0d_writes", idx), nwr, v.num);
    chk($sformatf("v%0d_update_count", idx), update_count, v.num);
    if (v.num != 0) begin
      chk($sformatf("v%0d_first_req_cycle", idx), first_req_k, 1);
      chk($sformatf("v%0d_addr_first", idx), af, v.a_first);
      chk($sformatf("v%0d_dout_first", idx), df, v.d_first);
      chk($sformatf("v%0d_addr_last", idx), al, v.a_last);
      chk($sformatf("v%0d_dout_last", idx), dl, v.d_last);
    end else begin
      chk($sformatf("v%0d_no_req", idx), first_req_k, -1);
    end
    @(negedge clk);
    chk($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
    chk($sformatf("v%0d_idle_done", idx), done, 1'b0);
    for (int k = 0; k < 5; k++) begin
      if (mem.req || busy) nreq++;
      @(negedge clk);
    end
    chk($sformatf("v%0d_quiet_after", idx), nreq, 0);
    chk($sformatf("v%0d_count_held", idx), update_count, v.num);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs_seen;

    vecs[0] = '{64'h1, 64'hFF, 32'd2, 1'b0, 64'h10, 64'h02, 64'h12, 64'h04, 64'h14};
    vecs[1] = '{64'h0, 64'hFFFF, 32'd1, 1'b0, 64'h0, 64'h2, 64'h2, 64'h2, 64'h2};
    vecs[2] = '{64'h5, 64'hF, 32'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA, 64'h0, 64'hA, 64'h0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 1'b0, 64'h0,
                64'h7, 64'h7, 64'h7, 64'h7};
    vecs[4] = '{64'hC000_0000_0000_0001, 64'hF0, 32'd3, 1'b1, 64'h41,
                64'h00, 64'h42, 64'h10, 64'h42};
    vecs[5] = '{64'h1, 64'hFF, 32'd0, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0;
    seed = '0; range = '0; num_updates = '0;
    mem.data_in = '0; mem.ready = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_req", mem.req, 1'b0);
    chk("rst_write", mem.write, 1'b0);
    chk("rst_count", update_count, '0);
    chk("rst_address", mem.address, '0);
    chk("rst_dout", mem.dout, '0);

    // Reset wins over a simultaneous start.
    start = 1'b1; num_updates = 32'd2; seed = 64'h1; range = 64'hFF;
    @(negedge clk);
    chk("rst_over_start_busy", busy, 1'b0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_no_req", mem.req, 1'b0);

    foreach (vecs[i]) run_vec(i, vecs[i], 1'b0);

    // Inputs changed and start re-pulsed mid-run: same results as vector 0.
    run_vec(6, vecs[0], 1'b1);

    // Slow read with abort pulsed in RD.
    seed = 64'h1; range = 64'hFF; mode = 1'b0; num_updates = 32'd4;
    mem.ready = 1'b0; mem.data_in = 64'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ab_gen_busy", busy, 1'b1);
    chk("ab_gen_req", mem.req, 1'b0);
    @(negedge clk);
    chk("ab_rd_req", mem.req, 1'b1);
    chk("ab_rd_write", mem.write, 1'b0);
    chk("ab_rd_addr", mem.address, 64'h2);
    abort = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      abort = 1'b0;
      chk($sformatf("ab_hold%0d_req", i), mem.req, 1'b1);
      chk($sformatf("ab_hold%0d_addr", i), mem.address, 64'h2);
      chk($sformatf("ab_hold%0d_write", i), mem.write, 1'b0);
    end
    mem.ready = 1'b1;
    @(negedge clk);
    mem.ready = 1'b0;
    chk("ab_wr_write", mem.write, 1'b1);
    chk("ab_wr_req", mem.req, 1'b1);
    chk("ab_wr_addr", mem.address, 64'h2);
    chk("ab_wr_dout", mem.dout, 64'h22);
    @(negedge clk);
    chk("ab_wr_hold", mem.write, 1'b1);
    mem.ready = 1'b1;
    @(negedge clk);
    mem.ready = 1'b0;
    chk("ab_done", done, 1'b1);
    chk("ab_count", update_count, 32'd1);
    chk("ab_done_req", mem.req, 1'b0);
    reqs_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem.req) reqs_seen++;
    end
    chk("ab_no_more_req", reqs_seen, 0);
    chk("ab_count_held", update_count, 32'd1);

    // Reset during the second write.
    seed = 64'h1; range = 64'hFF; mode = 1'b0; num_updates = 32'd3;
    mem.ready = 1'b1; mem.data_in = 64'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rw_in_write", mem.write, 1'b1);
    chk("rw_count_before", update_count, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_req", mem.req, 1'b0);
    chk("rw_busy", busy, 1'b0);
    chk("rw_count", update_count, '0);
    reqs_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem.req) reqs_seen++;
    end
    chk("rw_quiet", reqs_seen, 0);
    run_vec(7, vecs[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gups_engine.md
GUPS_ENGINE -- requirements
Module: gups_engine

Interface
REQ-001 Parameter DATA_W, default 64: data and LFSR width.
REQ-002 Parameter ADDR_W, default 64: address width, must be ≤ DATA_W.
REQ-003 Parameter CNT_W, default 32: update-count width.
REQ-004 Parameter POLY, default 64'h7: LFSR feedback constant, truncated to DATA_W.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a run; ignored unless the FSM is in IDLE.
REQ-008 abort  in  1  level; requests early termination of a run.
REQ-009 seed  in  DATA_W  initial LFSR value.
REQ-010 range  in  ADDR_W  address mask.
REQ-011 num_updates  in  CNT_W  number of read-modify-write updates to perform.
REQ-012 mode  in  1  update operation: 0 = XOR with LFSR value, 1 = increment by one.
REQ-013 req  out  1  memory request.
REQ-014 write  out  1  qualifies req: 1 = write, 0 = read.
REQ-015 address  out  ADDR_W  memory address.
REQ-016 dout  out  DATA_W  write data.
REQ-017 data_in  in  DATA_W  read data, valid on the cycle ready=1 during a read.
REQ-018 ready  in  1  memory completion strobe; one pulse completes the current transaction.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse at the end of a run.
REQ-021 update_count  out  CNT_W  number of completed updates in the current or last run.

Function
REQ-022 FSM states are IDLE, GEN, RD, WR and DONE, with a registered state.
REQ-023 IDLE with start=1: latch num_updates, range and mode; load the LFSR with seed, or with 1 if seed==0; clear update_count; go to GEN, or go to DONE if num_updates==0.
REQ-024 LFSR step: next = {ran[DATA_W-2:0],1'b0} ^ (ran[DATA_W-1] ? POLY : 0).
REQ-025 GEN lasts one cycle: advance the LFSR once and go to RD.
REQ-026 address shall always equal ran[ADDR_W-1:0] & latched range, held stable through RD and WR.
REQ-027 RD: req=1, write=0; on ready=1, capture upd = (mode ? data_in+1 : data_in ^ ran) modulo 2^DATA_W and go to WR.
REQ-028 WR: req=1, write=1, dout=upd; on ready=1, increment update_count.
REQ-029 On WR exit: go to DONE if the new count equals latched num_updates or abort_pend=1; otherwise go to GEN.
REQ-030 DONE lasts one cycle: done=1 for that cycle, then go to IDLE.
REQ-031 abort=1 in any busy state sets abort_pend.
REQ-032 abort in GEN goes directly to DONE with no request issued.
REQ-033 abort in RD or WR never drops req mid-transaction; the current update completes, then the FSM goes to DONE.
REQ-034 abort_pend is cleared in IDLE.
REQ-035 req is low in IDLE, GEN and DONE; write is low except in WR.
REQ-036 Changes to num_updates, range or mode during a run have no effect.
REQ-037 A start asserted while busy is dropped, not queued.
REQ-038 update_count holds its value in IDLE until the next accepted start.
REQ-039 update_count wraps modulo 2^CNT_W.
REQ-040 Throughput with ready held high is 3 cycles per update; first req is high 2 cycles after the start edge.
REQ-041 ready while req=0 is ignored.

Reset
REQ-042 reset=1 at a clock edge forces state=IDLE, req=0, write=0, busy=0, done=0, update_count=0, dout=0, address=0, LFSR=0 and abort_pend=0.
REQ-043 reset overrides start, abort and ready on the same edge.
REQ-044 reset mid-run abandons the outstanding transaction with no further req.

Verification
REQ-045 seed=1, range=0xFF, mode=0, num_updates=2, ready always 1, data_in=0x10 -> addresses 0x02 then 0x04; dout 0x12 then 0x14; done after 6 update cycles; update_count=2.
REQ-046 mode=1, data_in=0xFFFF_FFFF_FFFF_FFFF -> dout=0.
REQ-047 seed=0 -> first address 0x2.
REQ-048 num_updates=0 -> done one cycle after start; req never asserted; update_count=0.
REQ-049 ready delayed 5 cycles in RD, with abort pulsed in RD -> req and address held stable; write phase completes; update_count=1; done pulses; no further req.
REQ-050 reset asserted during WR -> next cycle req=0, busy=0, update_count=0; a later start runs normally from seed.
